md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle multiply/divide sequencer in the EX stage, between the main decoder's `startDiv`/`Sign`/`annul` controls and the HI/LO register file. Accepts one MULT/MULTU/DIV/DIVU operation at a time. Stalls the pipeline while the operation runs. Presents the 64-bit result as `{hi_o, lo_o}` with a one-cycle `ready_o` pulse, which the datapath uses as the HI/LO write source (`DataToHI/DataToLO` = 01 mult, 10 div).

## Interface
- `DIV_CYCLES`, 32, number of divider iterations (one quotient bit per cycle); must equal operand width.
- `WIDTH`, 32, operand width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `start_div`  in  1  request a divide; sampled only in IDLE.
- `start_mult`  in  1  request a multiply; sampled only in IDLE.
- `sign`  in  1  1 = signed (DIV/MULT), 0 = unsigned; latched with the operands.
- `annul`  in  1  cancel the in-flight operation (pipeline flush/exception).
- `opdata1`  in  WIDTH  dividend / multiplicand (rs).
- `opdata2`  in  WIDTH  divisor / multiplier (rt).
- `hi_o`  out  WIDTH  remainder (div) or product[63:32] (mult).
- `lo_o`  out  WIDTH  quotient (div) or product[31:0] (mult).
- `ready_o`  out  1  result valid, single-cycle pulse.
- `stall_o`  out  1  hold IF/ID/EX while the operation is busy.

## Operation
- State machine has four states: IDLE, MUL, DIV, DONE.
- Reset forces state = IDLE, iteration counter = 0, `hi_o` = `lo_o` = 0, `ready_o` = 0, `stall_o` = 0.
- IDLE:
  - `start_div` moves to DIV; otherwise `start_mult` moves to MUL.
  - If both are high, divide wins.
  - Operands and `sign` are latched on acceptance.
- MUL: computes the 64-bit product (signed when `sign`=1, else unsigned) into the result register, then goes to DIV... no: goes to DONE.
- DIV: restoring division on operand magnitudes.
  - Each cycle, shift the partial remainder left by one and bring in the next dividend bit.
  - Trial-subtract the divisor. A non-negative trial sets the quotient bit to 1 and keeps the difference.
  - The counter runs 0..DIV_CYCLES-1; the last iteration moves to DONE.
  - Sign fix-up in the final cycle: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - Unsigned ops skip both the magnitude conversion and the fix-up.
- DONE: asserts `ready_o` for exactly one cycle, then returns to IDLE. `hi_o`/`lo_o` hold until the next completion.
- Starts arriving while not in IDLE are ignored.
- `annul`:
  - In MUL/DIV/DONE it forces IDLE next cycle; `ready_o` stays 0 and `hi_o`/`lo_o` keep their previous values.
  - In IDLE, `annul` blocks a simultaneous start.
- Divide-by-zero (no macro): the full DIV_CYCLES iterations run.
  - Unsigned result: LO = 0xFFFFFFFF, HI = opdata1.
  - Signed result: HI = opdata1; LO = 0xFFFFFFFF if opdata1 ≥ 0, else 0x00000001.
- Overflow case 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0. Arithmetic is modulo 2^32, with magnitudes held in WIDTH+1 bits.

## Timing
- Cycle 0 is the start cycle in IDLE.
- `stall_o` is combinational: `(state==IDLE & (start_div|start_mult) & ~annul) | state==MUL | state==DIV`, then masked with `~annul`.
- Multiply: MUL at cycle 1, DONE (`ready_o`=1, `stall_o`=0) at cycle 2.
- Divide: DIV during cycles 1..DIV_CYCLES, DONE at cycle DIV_CYCLES+1 (33).
- A new start is accepted no earlier than the cycle after DONE.
- Reset asserted mid-operation clears immediately (asynchronous); no ready pulse follows.

## Configuration
- `MD_DIVZERO_FAST_EN`
  - Defined: a zero divisor goes IDLE → DONE directly (`ready_o` at cycle 1, stall for 1 cycle), with HI = LO = 0.
  - Undefined: the divide-by-zero behaviour in Operation applies, taking the full 33-cycle latency.

## Structure
- `defines.vh` holds:
  - state encodings `MD_IDLE`/`MD_MUL`/`MD_DIV`/`MD_DONE` (2 bits);
  - `MD_DIV_CYCLES`;
  - the DataToHI/LO select codes `MD_SRC_ALU`=00, `MD_SRC_MUL`=01, `MD_SRC_DIV`=10.
- Sub-module `div_core`: the restoring-divider datapath (partial remainder, quotient shift register, trial subtract, sign fix-up). It is driven by `load`/`step`/`finish` strobes from the sequencer FSM.
- The multiplier stays inline in `md_sequencer`.

## Test plan
- Unsigned multiply, `start_mult`, `sign`=0, 0xFFFFFFFF × 0x00000002 → cycle 2: `ready_o`=1, HI=0x00000001, LO=0xFFFFFFFE; `stall_o`=1 for cycles 0–1 only.
- Signed divide, `start_div`, `sign`=1, 0xFFFFFFF9 (−7) ÷ 2 → cycle 33: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); `stall_o` high for cycles 0–32.
- Annul mid-divide: `annul` at cycle 10 → IDLE at cycle 11, `stall_o`=0 from cycle 10, no `ready_o`, HI/LO unchanged. A new multiply started at cycle 12 completes normally.
- Simultaneous `start_div` and `start_mult`, 100 ÷ 7 unsigned → divide executed, cycle 33: LO=14, HI=2. Starts pulsed during DIV are ignored.
- Divide by zero, unsigned 0x12345678 ÷ 0:
  - without macro → cycle 33: LO=0xFFFFFFFF, HI=0x12345678;
  - with `MD_DIVZERO_FAST_EN` → cycle 1: HI=LO=0.
- `resetn` low at cycle 5 of a divide → all outputs 0 immediately, state IDLE, no `ready_o` after release.

Source files
------------

// File: rtl/md_sequencer_pkg.sv
// Shared state encodings and HI/LO source select codes for the multiply/divide sequencer.
// Used by md_sequencer, whose fast divide-by-zero path is enabled by MD_DIVZERO_FAST_EN.
package md_sequencer_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  localparam int MD_DIV_CYCLES = 32;

  // DataToHI/DataToLO select codes seen by the datapath
  localparam logic [1:0] MD_SRC_ALU = 2'b00;
  localparam logic [1:0] MD_SRC_MUL = 2'b01;
  localparam logic [1:0] MD_SRC_DIV = 2'b10;

endpackage

// File: rtl/md_sequencer_div_core.sv
// Restoring-divider datapath (div_core): one quotient bit per step, sign fix-up on finish.
// Behaviour is independent of MD_DIVZERO_FAST_EN; a zero divisor simply yields all-ones quotient bits.
module md_sequencer_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             finish_i,
  input  logic             sign_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [WIDTH-1:0] dvd_q, dvs_q, rem_q;
  logic             negq_q, negr_q;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   rem_shift, trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_next, quot_next;

  assign dvd_mag = (sign_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
  assign dvs_mag = (sign_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;

  // The dividend register doubles as the quotient shift register: dividend bits
  // leave at the top while quotient bits enter at the bottom.
  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign qbit      = ~trial[WIDTH];
  assign rem_next  = qbit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
  assign quot_next = {dvd_q[WIDTH-2:0], qbit};

  assign quot_o = finish_i ? (negq_q ? -quot_next : quot_next) : '0;
  assign rem_o  = finish_i ? (negr_q ? -rem_next  : rem_next)  : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      rem_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (load_i) begin
      dvd_q  <= dvd_mag;
      dvs_q  <= dvs_mag;
      rem_q  <= '0;
      negq_q <= sign_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
      negr_q <= sign_i & dividend_i[WIDTH-1];
    end else if (step_i) begin
      dvd_q <= quot_next;
      rem_q <= rem_next;
    end
  end

endmodule

// File: rtl/md_sequencer.sv
// EX-stage multiply/divide sequencer: stalls the pipe while busy, pulses ready_o with {hi_o, lo_o}.
// Define MD_DIVZERO_FAST_EN to finish a zero-divisor divide in one cycle with HI = LO = 0.
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int DIV_CYCLES = MD_DIV_CYCLES,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_div,
  input  logic             start_mult,
  input  logic             sign,
  input  logic             annul,
  input  logic [WIDTH-1:0] opdata1,
  input  logic [WIDTH-1:0] opdata2,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             ready_o,
  output logic             stall_o
);

  localparam int CW = $clog2(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_CYCLES - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
  logic             sign_q;
  logic             mul_load, mul_wr, div_load, div_step, div_finish, zero_wr;
  logic [2*WIDTH-1:0] a_ext, b_ext, product;
  logic [WIDTH-1:0] div_quot, div_rem;

  md_sequencer_div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (div_load),
    .step_i     (div_step),
    .finish_i   (div_finish),
    .sign_i     (sign),
    .dividend_i (opdata1),
    .divisor_i  (opdata2),
    .quot_o     (div_quot),
    .rem_o      (div_rem)
  );

  // Sign-extend to full product width so one unsigned multiply serves MULT and MULTU.
  assign a_ext   = sign_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign b_ext   = sign_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign product = a_ext * b_ext;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mul_load   = 1'b0;
    mul_wr     = 1'b0;
    div_load   = 1'b0;
    div_step   = 1'b0;
    div_finish = 1'b0;
    zero_wr    = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (!annul) begin
          if (start_div) begin
`ifdef MD_DIVZERO_FAST_EN
            if (opdata2 == '0) begin
              zero_wr = 1'b1;
              state_d = MD_DONE;
            end else begin
              div_load = 1'b1;
              cnt_d    = '0;
              state_d  = MD_DIV;
            end
`else
            div_load = 1'b1;
            cnt_d    = '0;
            state_d  = MD_DIV;
`endif
          end else if (start_mult) begin
            mul_load = 1'b1;
            state_d  = MD_MUL;
          end
        end
      end
      MD_MUL: begin
        if (annul) begin
          state_d = MD_IDLE;
        end else begin
          mul_wr  = 1'b1;
          state_d = MD_DONE;
        end
      end
      MD_DIV: begin
        if (annul) begin
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          div_step = 1'b1;
          if (cnt_q == CNT_LAST) begin
            div_finish = 1'b1;
            cnt_d      = '0;
            state_d    = MD_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (mul_load) begin
        a_q    <= opdata1;
        b_q    <= opdata2;
        sign_q <= sign;
      end
      if (mul_wr) begin
        hi_q <= product[2*WIDTH-1:WIDTH];
        lo_q <= product[WIDTH-1:0];
      end else if (div_finish) begin
        hi_q <= div_rem;
        lo_q <= div_quot;
      end else if (zero_wr) begin
        hi_q <= '0;
        lo_q <= '0;
      end
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign ready_o = (state_q == MD_DONE) && !annul;
  assign stall_o = ((state_q == MD_IDLE && (start_div || start_mult)) ||
                    state_q == MD_MUL || state_q == MD_DIV) && !annul;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: multiply, divide, annul, divide-by-zero and async reset.
// Divide-by-zero expectations follow MD_DIVZERO_FAST_EN when it is defined.
module tb_md_sequencer;

  logic        clk;
  logic        resetn;
  logic        start_div, start_mult, sign, annul;
  logic [31:0] opdata1, opdata2;
  logic [31:0] hi_o, lo_o;
  logic        ready_o, stall_o;

  int totalChecks  = 0;
  int passedChecks = 0;

  md_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .start_div  (start_div),
    .start_mult (start_mult),
    .sign       (sign),
    .annul      (annul),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .ready_o    (ready_o),
    .stall_o    (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    totalChecks++;
    if (observed === expected) passedChecks++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic dv, input logic ml, input logic sg, input logic an,
                               input logic [31:0] a, input logic [31:0] b);
    start_div  = dv;
    start_mult = ml;
    sign       = sg;
    annul      = an;
    opdata1    = a;
    opdata2    = b;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mulOp(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expProd);
    nextCycle();
    applyStimulus(1'b0, 1'b1, sg, 1'b0, a, b);
    #3;
    checkOutput({tag, "_c0_stall"}, {63'd0, stall_o}, 64'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    checkOutput({tag, "_c1_stall_ready"}, {62'd0, stall_o, ready_o}, 64'd2);
    nextCycle();
    #3;
    checkOutput({tag, "_c2_stall_ready"}, {62'd0, stall_o, ready_o}, 64'd1);
    checkOutput({tag, "_c2_result"}, {hi_o, lo_o}, expProd);
    nextCycle();
    #3;
    checkOutput({tag, "_c3_ready"}, {63'd0, ready_o}, 64'd0);
  endtask

  // lat is the cycle index of the DONE cycle; noisy pulses stray starts mid-operation
  task automatic divOp(input string tag, input logic sg, input logic both, input logic [31:0] a,
                       input logic [31:0] b, input int lat, input logic [63:0] expRes);
    int bad;
    nextCycle();
    applyStimulus(1'b1, both, sg, 1'b0, a, b);
    #3;
    checkOutput({tag, "_c0_stall"}, {63'd0, stall_o}, 64'd1);
    bad = 0;
    for (int c = 1; c < lat; c++) begin
      nextCycle();
      if (both && (c == 5 || c == 20))
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd9, 32'd3);
      else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #3;
      if (stall_o !== 1'b1 || ready_o !== 1'b0) bad++;
    end
    checkOutput({tag, "_busy_cycles_bad"}, 64'(bad), 64'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    checkOutput({tag, "_done_stall_ready"}, {62'd0, stall_o, ready_o}, 64'd1);
    checkOutput({tag, "_done_result"}, {hi_o, lo_o}, expRes);
    nextCycle();
    #3;
    checkOutput({tag, "_after_ready"}, {63'd0, ready_o}, 64'd0);
  endtask

  initial begin
    int readyCount;
    resetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    checkOutput("reset_outputs", {hi_o, lo_o}, 64'd0);
    checkOutput("reset_ready_stall", {62'd0, ready_o, stall_o}, 64'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    mulOp("mulu_ffff_x2", 1'b0, 32'hFFFFFFFF, 32'h00000002, 64'h00000001_FFFFFFFE);
    divOp("divs_m7_2", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 33, 64'hFFFFFFFF_FFFFFFFD);

    // Annul at cycle 10 of a divide; result registers must keep the previous divide result.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    nextCycle();
    annul = 1'b1;
    #3;
    checkOutput("annul_c10_stall_ready", {62'd0, stall_o, ready_o}, 64'd0);
    nextCycle();
    annul = 1'b0;
    #3;
    checkOutput("annul_c11_stall_ready", {62'd0, stall_o, ready_o}, 64'd0);
    checkOutput("annul_c11_result_kept", {hi_o, lo_o}, 64'hFFFFFFFF_FFFFFFFD);
    mulOp("muls_m3_x5", 1'b1, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1);

    divOp("divu_both_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 33, {32'd2, 32'd14});
`ifdef MD_DIVZERO_FAST_EN
    divOp("divu_zero_fast", 1'b0, 1'b0, 32'h12345678, 32'd0, 1, 64'd0);
`else
    divOp("divu_zero", 1'b0, 1'b0, 32'h12345678, 32'd0, 33, 64'h12345678_FFFFFFFF);
    divOp("divs_zero_neg", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd0, 33, 64'hFFFFFFF9_00000001);
`endif
    divOp("divs_overflow", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000);
    mulOp("muls_min_x2", 1'b1, 32'h80000000, 32'd2, 64'hFFFFFFFF_00000000);
    divOp("divs_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD);

    // Asynchronous reset at cycle 5 of a divide.
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd1000, 32'd3);
    for (int c = 1; c < 5; c++) begin
      nextCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
    nextCycle();
    resetn = 1'b0;
    #1;
    checkOutput("rst_mid_result", {hi_o, lo_o}, 64'd0);
    checkOutput("rst_mid_ready_stall", {62'd0, ready_o, stall_o}, 64'd0);
    nextCycle();
    resetn = 1'b1;
    readyCount = 0;
    for (int c = 0; c < 40; c++) begin
      nextCycle();
      #3;
      if (ready_o !== 1'b0 || stall_o !== 1'b0) readyCount++;
    end
    checkOutput("rst_no_ready_after", 64'(readyCount), 64'd0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
